// File: rtl/aes_pkg.sv
// aes_pkg: shared constants, FSM state type and GF(2^8) round helpers for
// the aes_core_v2 block-cipher engine.
//   RND_SIZE/WRD_SIZE/NUM_BLK/KEY_MAX/CNT_SIZE : datapath geometry
//   NR_128/NR_256                               : round counts per key length
//   aes_state_e                                 : IDLE/RUN/DONE
//   rcon, xtime, shift_rows, mix_column(s)      : combinational round helpers
// State byte k of a 128-bit block lives at bits [127-8k -: 8]; column c is
// bytes 4c..4c+3 (row 0 at the MSB end of the column word).
package aes_pkg;

    localparam int RND_SIZE = 128;
    localparam int WRD_SIZE = 32;
    localparam int NUM_BLK  = 4;
    localparam int KEY_MAX  = 256;
    localparam int CNT_SIZE = 4;

    localparam logic [CNT_SIZE-1:0] NR_128 = 4'd10;
    localparam logic [CNT_SIZE-1:0] NR_256 = 4'd14;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } aes_state_e;

    function automatic logic [7:0] rcon(input logic [CNT_SIZE-1:0] idx);
        logic [7:0] rc;
        case (idx)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    // Multiply by x modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        r = 128'h0;
        for (int c = 0; c < NUM_BLK; c++) begin
            r[127 - 32*c -: 32] = mix_column(s[127 - 32*c -: 32]);
        end
        return r;
    endfunction

    // Row w is rotated left by w columns
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int w = 0; w < 4; w++) begin
                r[127 - 8*(4*c + w) -: 8] = s[127 - 8*(4*((c + w) % 4) + w) -: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_core_v2_if.sv
// aes_core_v2_if: block-in / ciphertext-out bus of aes_core_v2.
//   i_en, i_key_256, i_msg, i_key : input block and key (valid/ready with o_ready)
//   o_ready                       : core can accept a block
//   o_valid, o_cypher             : ciphertext, held until i_out_ready
//   i_out_ready                   : downstream takes o_cypher
// master = upstream/downstream side, slave = the core.
interface aes_core_v2_if;
    import aes_pkg::*;

    logic                i_en;
    logic                i_key_256;
    logic [RND_SIZE-1:0] i_msg;
    logic [KEY_MAX-1:0]  i_key;
    logic                o_ready;
    logic                o_valid;
    logic                i_out_ready;
    logic [RND_SIZE-1:0] o_cypher;

    modport master (
        output i_en, i_key_256, i_msg, i_key, i_out_ready,
        input  o_ready, o_valid, o_cypher
    );

    modport slave (
        input  i_en, i_key_256, i_msg, i_key, i_out_ready,
        output o_ready, o_valid, o_cypher
    );

endinterface

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES forward S-box.
//   byte_i : input byte
//   byte_o : substituted byte
module aes_sbox (
    input  logic [7:0] byte_i,
    output logic [7:0] byte_o
);

    // Entry for input 0 sits at the MSB end
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] idx_s;

    // Bit offset of the entry: 8 * (255 - byte_i)
    assign idx_s  = {~byte_i, 3'b000};
    assign byte_o = SBOX_TABLE[idx_s +: 8];

endmodule

// File: rtl/aes_core_v2.sv
// aes_core_v2: iterative AES encryption core, one round per clock, with
// on-the-fly key expansion and a valid/ready ciphertext handshake.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : aes_core_v2_if.slave (block/key in, ciphertext out)
//   busy : high while a block is in RUN or DONE
// Build option AES_CORE_V2_256_EN: when defined, AES-256 (8-word key window,
// odd-round SubWord-only step) is compiled in; otherwise the core is
// AES-128 only, i_key_256 and i_key[127:0] are ignored and Nr is 10.
module aes_core_v2
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    aes_core_v2_if.slave bus,
    output logic         busy
);

    aes_state_e          state_q, state_d;
    logic [CNT_SIZE-1:0] rnd_q, rnd_d;
    logic [RND_SIZE-1:0] blk_q, blk_d;
    logic [RND_SIZE-1:0] key_hi_q, key_hi_d;
    logic                o_ready_q, o_valid_q, busy_q;

    logic                accept_s, last_s, rot_en_s;
    logic [CNT_SIZE-1:0] nr_s, rcon_idx_s;
    logic [WRD_SIZE-1:0] key_last_s, sub_word_s, temp_s;
    logic [WRD_SIZE-1:0] w0_s, w1_s, w2_s, w3_s;
    logic [RND_SIZE-1:0] sub_s, sr_s, mc_s, rk_s, exp_rk_s, key_hi_next_s;

    assign accept_s = (state_q == IDLE) & o_ready_q & bus.i_en;
    assign last_s   = (rnd_q == nr_s);

`ifdef AES_CORE_V2_256_EN
    logic                mode_q, mode_d;
    logic [RND_SIZE-1:0] key_lo_q, key_lo_d;
    logic                first_256_s;

    // Key-schedule controls selected by the latched key length
    always_comb begin
        first_256_s = mode_q & (rnd_q == 4'd1);
        nr_s        = mode_q ? NR_256 : NR_128;
        key_last_s  = mode_q ? key_lo_q[WRD_SIZE-1:0] : key_hi_q[WRD_SIZE-1:0];
        rot_en_s    = ~(mode_q & rnd_q[0]);
        rcon_idx_s  = mode_q ? {1'b0, rnd_q[CNT_SIZE-1:1]} : rnd_q;
    end

    // Round 1 of AES-256 uses the second key half directly; afterwards the
    // window (key_hi, key_lo) slides by one freshly expanded round key
    always_comb begin
        rk_s = first_256_s ? key_lo_q : exp_rk_s;
        if (!mode_q) begin
            key_hi_next_s = exp_rk_s;
        end else if (first_256_s) begin
            key_hi_next_s = key_hi_q;
        end else begin
            key_hi_next_s = key_lo_q;
        end
    end

    // Upper window half and latched mode
    always_comb begin
        mode_d   = mode_q;
        key_lo_d = key_lo_q;
        if (accept_s) begin
            mode_d   = bus.i_key_256;
            key_lo_d = bus.i_key[RND_SIZE-1:0];
        end else if ((state_q == RUN) && mode_q && !first_256_s) begin
            key_lo_d = exp_rk_s;
        end else begin
            key_lo_d = key_lo_q;
        end
    end

    // AES-256 key window and mode registers
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= 1'b0;
            key_lo_q <= {RND_SIZE{1'b0}};
        end else begin
            mode_q   <= mode_d;
            key_lo_q <= key_lo_d;
        end
    end
`else
    logic unused_s;

    // Fixed AES-128 key-schedule controls
    always_comb begin
        nr_s       = NR_128;
        key_last_s = key_hi_q[WRD_SIZE-1:0];
        rot_en_s   = 1'b1;
        rcon_idx_s = rnd_q;
    end

    assign rk_s          = exp_rk_s;
    assign key_hi_next_s = exp_rk_s;
    assign unused_s      = ^{bus.i_key_256, bus.i_key[RND_SIZE-1:0]};
`endif

    for (genvar g = 0; g < 4; g++) begin : g_sub_word
        aes_sbox u_sbox (.byte_i(key_last_s[8*g +: 8]), .byte_o(sub_word_s[8*g +: 8]));
    end

    // SubWord is bytewise, so RotWord can be applied after it
    assign temp_s   = rot_en_s ? ({sub_word_s[23:0], sub_word_s[31:24]} ^ {rcon(rcon_idx_s), 24'h000000})
                               : sub_word_s;
    assign w0_s     = key_hi_q[127:96] ^ temp_s;
    assign w1_s     = key_hi_q[95:64]  ^ w0_s;
    assign w2_s     = key_hi_q[63:32]  ^ w1_s;
    assign w3_s     = key_hi_q[31:0]   ^ w2_s;
    assign exp_rk_s = {w0_s, w1_s, w2_s, w3_s};

    for (genvar g = 0; g < 4*NUM_BLK; g++) begin : g_sub_bytes
        aes_sbox u_sbox (.byte_i(blk_q[8*g +: 8]), .byte_o(sub_s[8*g +: 8]));
    end

    assign sr_s = shift_rows(sub_s);
    assign mc_s = mix_columns(sr_s);

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        rnd_d    = rnd_q;
        blk_d    = blk_q;
        key_hi_d = key_hi_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d  = RUN;
                    rnd_d    = 4'd1;
                    blk_d    = bus.i_msg ^ bus.i_key[KEY_MAX-1 -: RND_SIZE];
                    key_hi_d = bus.i_key[KEY_MAX-1 -: RND_SIZE];
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                rnd_d    = rnd_q + 4'd1;
                blk_d    = (last_s ? sr_s : mc_s) ^ rk_s;
                key_hi_d = key_hi_next_s;
                if (last_s) begin
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (bus.i_out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, datapath and handshake registers (outputs follow next state)
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rnd_q     <= {CNT_SIZE{1'b0}};
            blk_q     <= {RND_SIZE{1'b0}};
            key_hi_q  <= {RND_SIZE{1'b0}};
            o_ready_q <= 1'b0;
            o_valid_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rnd_q     <= rnd_d;
            blk_q     <= blk_d;
            key_hi_q  <= key_hi_d;
            o_ready_q <= (state_d == IDLE);
            o_valid_q <= (state_d == DONE);
            busy_q    <= (state_d != IDLE);
        end
    end

    assign bus.o_ready  = o_ready_q;
    assign bus.o_valid  = o_valid_q;
    assign bus.o_cypher = blk_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_aes_core_v2.sv
// tb_aes_core_v2: self-checking bench for aes_core_v2. Expected ciphertexts
// come from a byte-level AES model (S-box derived from the GF(2^8) inverse
// and affine map, FIPS-style word key expansion) plus FIPS-197 literals.
module tb_aes_core_v2;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] sb [0:255];

    aes_core_v2_if bus ();

    aes_core_v2 dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse then affine map
    function automatic logic [7:0] sbox_def(input logic [7:0] v);
        logic [7:0] inv;
        logic [7:0] b;
        logic [7:0] s;
        inv = 8'h00;
        if (v != 8'h00) begin
            inv = 8'h01;
            for (int e = 0; e < 254; e++) inv = gmul(inv, v);
        end
        b = inv;
        s = inv;
        for (int k = 0; k < 4; k++) begin
            b = {b[6:0], b[7]};
            s = s ^ b;
        end
        return s ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] msg, input logic [255:0] key, input bit is256);
        logic [31:0]  w  [0:59];
        logic [7:0]   st [0:15];
        logic [7:0]   sh [0:15];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        int nk;
        int nr;
        nk = is256 ? 8 : 4;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end else if (nk == 8 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int j = 0; j < 16; j++) st[j] = msg[127 - 8*j -: 8] ^ w[j/4][31 - 8*(j%4) -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    sh[4*c + row] = sb[st[4*((c + row) % 4) + row]];
            if (r != nr) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = sh[4*c]; a1 = sh[4*c+1]; a2 = sh[4*c+2]; a3 = sh[4*c+3];
                    sh[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    sh[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    sh[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    sh[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int j = 0; j < 16; j++) st[j] = sh[j] ^ w[4*r + j/4][31 - 8*(j%4) -: 8];
        end
        res = 128'h0;
        for (int j = 0; j < 16; j++) res[127 - 8*j -: 8] = st[j];
        return res;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Push one block through, checking latency, result, backpressure and release
    task automatic run_block(input logic [127:0] msg, input logic [255:0] key, input bit m256,
                             input int bp, input bit noisy, output logic [127:0] got);
        logic [127:0] exp;
        int  nr_exp;
        int  k;
        bit  eff;
`ifdef AES_CORE_V2_256_EN
        eff = m256;
`else
        eff = 1'b0;
`endif
        nr_exp = eff ? 14 : 10;
        exp = aes_ref(msg, key, eff);
        k = 0;
        while (bus.o_ready !== 1'b1 && k < 30) begin
            tick();
            k++;
        end
        chk("ready_before_accept", bus.o_ready, 1);
        bus.i_en        = 1'b1;
        bus.i_msg       = msg;
        bus.i_key       = key;
        bus.i_key_256   = m256;
        bus.i_out_ready = (bp == 0);
        tick();
        bus.i_en      = noisy;
        bus.i_msg     = rnd128();
        bus.i_key     = {rnd128(), rnd128()};
        bus.i_key_256 = ~m256;
        chk("busy_after_accept", busy, 1);
        chk("ready_after_accept", bus.o_ready, 0);
        chk("valid_after_accept", bus.o_valid, 0);
        k = 0;
        while (bus.o_valid !== 1'b1 && k < 40) begin
            tick();
            k++;
            if (k == 2) bus.i_en = 1'b0;
        end
        bus.i_en = 1'b0;
        chk("latency", k, nr_exp);
        chk("cypher", bus.o_cypher, exp);
        chk("ready_in_done", bus.o_ready, 0);
        chk("busy_in_done", busy, 1);
        got = bus.o_cypher;
        for (int i = 0; i < bp; i++) begin
            tick();
            chk("bp_valid_held", bus.o_valid, 1);
            chk("bp_cypher_held", bus.o_cypher, exp);
            chk("bp_ready_low", bus.o_ready, 0);
        end
        bus.i_out_ready = 1'b1;
        tick();
        chk("valid_after_take", bus.o_valid, 0);
        chk("ready_after_take", bus.o_ready, 1);
        chk("busy_after_take", busy, 0);
    endtask

    localparam logic [127:0] FIPS_MSG = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_KEY   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [255:0] C3_KEY   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C1_CT    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] Z128_CT  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
`ifdef AES_CORE_V2_256_EN
    localparam logic [127:0] C3_CT    = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] Z256_CT  = 128'hdc95c078a2408989ad48a21492842087;
`else
    localparam logic [127:0] C3_CT    = C1_CT;
    localparam logic [127:0] Z256_CT  = Z128_CT;
`endif

    initial begin
        logic [127:0] got;
        bit           seen;
        for (int x = 0; x < 256; x++) sb[x] = sbox_def(8'(x));

        rst             = 1'b1;
        bus.i_en        = 1'b0;
        bus.i_key_256   = 1'b0;
        bus.i_msg       = 128'h0;
        bus.i_key       = 256'h0;
        bus.i_out_ready = 1'b1;
        tick();
        tick();
        chk("rst_ready", bus.o_ready, 0);
        chk("rst_valid", bus.o_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cypher", bus.o_cypher, 0);
        rst = 1'b0;
        tick();
        chk("ready_after_reset", bus.o_ready, 1);

        run_block(FIPS_MSG, {C1_KEY, rnd128()}, 1'b0, 0, 1'b0, got);
        chk("fips_c1", got, C1_CT);
        run_block(FIPS_MSG, C3_KEY, 1'b1, 0, 1'b0, got);
        chk("fips_c3", got, C3_CT);
        run_block(128'h0, 256'h0, 1'b0, 0, 1'b0, got);
        chk("zero_128", got, Z128_CT);
        run_block(128'h0, 256'h0, 1'b1, 0, 1'b0, got);
        chk("zero_256", got, Z256_CT);
        run_block(FIPS_MSG, {C1_KEY, 128'h0}, 1'b0, 20, 1'b0, got);
        chk("backpressure_c1", got, C1_CT);
        run_block(FIPS_MSG, C3_KEY, 1'b1, 2, 1'b1, got);
        chk("noisy_c3", got, C3_CT);

        // Reset in the middle of a block
        bus.i_en        = 1'b1;
        bus.i_msg       = FIPS_MSG;
        bus.i_key       = {C1_KEY, 128'h0};
        bus.i_key_256   = 1'b0;
        bus.i_out_ready = 1'b1;
        tick();
        bus.i_en = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        chk("midrst_ready", bus.o_ready, 0);
        chk("midrst_valid", bus.o_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_cypher", bus.o_cypher, 0);
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.o_valid !== 1'b0) seen = 1'b1;
        end
        chk("midrst_no_valid", seen, 0);
        run_block(FIPS_MSG, {C1_KEY, rnd128()}, 1'b0, 0, 1'b0, got);
        chk("post_rst_c1", got, C1_CT);

        for (int n = 0; n < 6; n++) begin
            run_block(rnd128(), {rnd128(), rnd128()}, 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), got);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_core_v2.md
# aes_core_v2

Iterative AES encryption core, successor to `aes_core_top`. It adds a selectable AES-256 key length with on-the-fly key expansion, and an output valid/ready handshake with backpressure. It processes one round per clock. It sits in the GCM datapath as the block-cipher engine feeding CTR keystream and H-subkey generation.

## Interface
Parameters:
- `RND_SIZE`, 128: block/state width in bits.
- `WRD_SIZE`, 32: word width.
- `NUM_BLK`, 4: words per block.
- `KEY_MAX`, 256: key port width.
- `CNT_SIZE`, 4: round counter width (holds 0..14).

Ports:
- `clk`, in, 1: single clock, all logic on the rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `i_en`, in, 1: input block valid.
- `i_key_256`, in, 1: 1 = AES-256, 0 = AES-128. Sampled at accept.
- `i_msg`, in, 128: plaintext block.
- `i_key`, in, 256: key. AES-128 uses `[255:128]`; AES-256 uses all bits. Word W0 is at the MSB end.
- `o_ready`, out, 1: core can accept a block.
- `o_valid`, out, 1: ciphertext valid, held until taken.
- `i_out_ready`, in, 1: downstream takes `o_cypher`.
- `o_cypher`, out, 128: ciphertext.
- `busy`, out, 1: high in RUN and DONE.

## Operation
- FSM states:
  - IDLE: `o_ready=1`. Accept occurs when `i_en & o_ready`. On accept:
    - `state <= i_msg ^ i_key[255:128]`
    - key regs latch `i_key`
    - mode latches `i_key_256`
    - `rnd <= 1`
    - go to RUN.
  - RUN: one full AES round per cycle (SubBytes, ShiftRows, MixColumns, AddRoundKey), `rnd++`. On the round where `rnd == Nr`, MixColumns is skipped and the FSM goes to DONE.
  - DONE: `o_valid=1` and `o_cypher` is stable. On `i_out_ready`, go to IDLE.
- Nr is 10 for AES-128 and 14 for AES-256.
- Round keys, 128-bit mode:
  - rk0 = key[255:128].
  - rk(r) is expanded from rk(r-1) combinationally in the same cycle it is used: RotWord, SubWord, Rcon[r].
- Round keys, 256-bit mode:
  - rk0 = key[255:128], rk1 = key[127:0].
  - An 8-word sliding window advances 4 words per round.
  - Even r uses RotWord+SubWord+Rcon[r/2]; odd r uses SubWord only.
- Mode and key are latched at accept. Later changes to `i_key`, `i_key_256` or `i_msg` have no effect on the block in flight.
- `i_en` outside IDLE is ignored. There is no queueing, and upstream must hold `i_en` until it sees `o_ready`.
- All arithmetic is GF(2^8) with polynomial 0x11B. There are no carries and no widening.

## Timing
- Reset values: `o_ready=0` during the reset cycle and 1 from the first cycle after reset deasserts. `o_valid=0`, `busy=0`, `o_cypher=0`. FSM resets to IDLE and `rnd` to 0.
- Latency: accept at edge E0, `o_valid` rises after edge E0+Nr. That is 10 cycles (AES-128) or 14 cycles (AES-256).
- Throughput: minimum Nr+2 cycles per block, since IDLE lasts at least one cycle after DONE.
- Backpressure: `o_valid` and `o_cypher` hold indefinitely while `i_out_ready=0`. If `i_out_ready=1` is already high on entering DONE, DONE lasts exactly one cycle.
- `rst` in any state returns to IDLE at the next edge with reset values. The in-flight block is discarded and no `o_valid` is produced for it.
- `o_ready` and `o_valid` are never high in the same cycle.

## Configuration
- `AES_CORE_V2_256_EN` defined: AES-256 path compiled in. This covers the 8-word key window and the odd-round SubWord-only step.
- Not defined:
  - `i_key_256` is ignored and treated as 0.
  - `i_key[127:0]` is unused.
  - Only the 4-word key register is built.
  - Nr is fixed at 10.

## Structure
- Package `aes_pkg` holds:
  - `RND_SIZE`, `WRD_SIZE`, `NUM_BLK` defaults
  - Nr constants 10 and 14
  - Rcon table
  - FSM state enum (IDLE/RUN/DONE)
  - `xtime` and MixColumns functions.
- Sub-module `aes_sbox`: combinational, 8-bit in and 8-bit out. It is instantiated 16 times for SubBytes and 4 times for SubWord.

## Test plan
- AES-128, FIPS-197 C.1: key 000102…0f, msg 00112233445566778899aabbccddeeff, `i_out_ready=1` → `o_cypher` = 69c4e0d86a7b0430d8cdb78070b4c55a, `o_valid` rising 10 cycles after accept.
- AES-256, FIPS-197 C.3: key 000102…1f, same msg → 8ea2b7ca516745bfeafc49904b496089, 14 cycles after accept.
- All-zero key and msg: AES-128 → 66e94bd4ef8a2c3b884cfa59ca342b2e; AES-256 → dc95c078a2408989ad48a21492842087.
- Backpressure: hold `i_out_ready=0` for 20 cycles → `o_valid` stays high, `o_cypher` stable, `o_ready` stays 0. Then pulse `i_out_ready` → IDLE the next cycle.
- Change `i_key`/`i_msg` and pulse `i_en` during RUN → result equals the vector of the originally accepted block, and the second pulse is ignored.
- Assert `rst` at round 5 → all outputs return to reset values next cycle, no `o_valid` appears, and a new C.1 block then completes correctly.
